hilo_pipe: RTL and testbench

Post-execute pipeline block of the MIPS32 core. It carries EX-stage results through two register stages, MEM and WB, and owns the architectural HI/LO register pair. It produces the GPR write-back port and a forwarded HI/LO view for instructions currently in EX. Stall and flush inputs come from the pipeline control unit.

---
 rtl/hilo_pipe.sv | 131 +++++++++++++
 tb/tb_hilo_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_pipe.sv
// hilo_pipe -- post-execute pipeline block of the MIPS32 core.
//
// Carries EX-stage results through the MEM and WB register stages, owns the
// architectural HI/LO pair and forwards the youngest in-flight HI/LO value
// back to the instruction currently in EX.
//
// Ports
//   clk, rst            : core clock, synchronous active-high reset
//   stall_i             : hold MEM contents, inject a bubble into WB
//   flush_i             : kill the instruction entering MEM (beats stall)
//   writeAddr_i         : GPR destination from EX
//   writeEnable_i       : GPR write request from EX
//   writeHILO_i         : {write HI, write LO} from EX
//   HI_data_i/LO_data_i : HI/LO results from EX (LO is also the GPR result)
//   mem_*_o             : MEM-stage GPR write (for GPR forwarding)
//   wb_*_o              : register-file write port
//   HI_o/LO_o           : forwarded HI/LO view for the instruction in EX
//
// Valid semantics: a stage's write-enable / hilo bits qualify its data
// fields; a stage with all qualifiers low is a bubble. There is no
// back-pressure path: the control unit's stall_i is the only hold.
module hilo_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [4:0]  writeAddr_i,
  input  logic        writeEnable_i,
  input  logic [1:0]  writeHILO_i,
  input  logic [31:0] HI_data_i,
  input  logic [31:0] LO_data_i,
  output logic [4:0]  mem_writeAddr_o,
  output logic        mem_writeEnable_o,
  output logic [31:0] mem_data_o,
  output logic [4:0]  wb_writeAddr_o,
  output logic        wb_writeEnable_o,
  output logic [31:0] wb_data_o,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);

  // MEM stage fields
  logic [4:0]  r_mem_addr;
  logic        r_mem_we;
  logic [1:0]  r_mem_hilo;
  logic [31:0] r_mem_hi;
  logic [31:0] r_mem_lo;

  // WB stage fields
  logic [4:0]  r_wb_addr;
  logic        r_wb_we;
  logic [1:0]  r_wb_hilo;
  logic [31:0] r_wb_hi;
  logic [31:0] r_wb_lo;

  // Architectural HI/LO
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // A write to $0 is dropped at capture so it can never appear on either
  // the forwarding or the register-file port.
  logic w_ex_we;
  assign w_ex_we = writeEnable_i & (writeAddr_i != 5'd0);

  // MEM stage: flush has priority over stall.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_mem_addr <= 5'd0;
      r_mem_we   <= 1'b0;
      r_mem_hilo <= 2'b00;
      r_mem_hi   <= 32'd0;
      r_mem_lo   <= 32'd0;
    end else if (!stall_i) begin
      r_mem_addr <= writeAddr_i;
      r_mem_we   <= w_ex_we;
      r_mem_hilo <= writeHILO_i;
      r_mem_hi   <= HI_data_i;
      r_mem_lo   <= LO_data_i;
    end
  end

  // WB stage: a stall leaves MEM in place, so WB must take a bubble or the
  // held instruction would commit once per stalled cycle.
  always_ff @(posedge clk) begin
    if (rst || stall_i) begin
      r_wb_addr <= 5'd0;
      r_wb_we   <= 1'b0;
      r_wb_hilo <= 2'b00;
      r_wb_hi   <= 32'd0;
      r_wb_lo   <= 32'd0;
    end else begin
      r_wb_addr <= r_mem_addr;
      r_wb_we   <= r_mem_we;
      r_wb_hilo <= r_mem_hilo;
      r_wb_hi   <= r_mem_hi;
      r_wb_lo   <= r_mem_lo;
    end
  end

  // HI/LO commit from WB; the halves are independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (r_wb_hilo[1]) r_hi <= r_wb_hi;
      if (r_wb_hilo[0]) r_lo <= r_wb_lo;
    end
  end

  // Forwarding: youngest writer (MEM) first, then WB, then the register.
  always_comb begin
    HI_o = r_hi;
    if (r_mem_hilo[1])     HI_o = r_mem_hi;
    else if (r_wb_hilo[1]) HI_o = r_wb_hi;
  end

  always_comb begin
    LO_o = r_lo;
    if (r_mem_hilo[0])     LO_o = r_mem_lo;
    else if (r_wb_hilo[0]) LO_o = r_wb_lo;
  end

  assign mem_writeAddr_o   = r_mem_addr;
  assign mem_writeEnable_o = r_mem_we;
  assign mem_data_o        = r_mem_lo;
  assign wb_writeAddr_o    = r_wb_addr;
  assign wb_writeEnable_o  = r_wb_we;
  assign wb_data_o         = r_wb_lo;

endmodule

// File: tb/tb_hilo_pipe.sv
module tb_hilo_pipe;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [4:0]  writeAddr_i;
  logic        writeEnable_i;
  logic [1:0]  writeHILO_i;
  logic [31:0] HI_data_i;
  logic [31:0] LO_data_i;
  logic [4:0]  mem_writeAddr_o;
  logic        mem_writeEnable_o;
  logic [31:0] mem_data_o;
  logic [4:0]  wb_writeAddr_o;
  logic        wb_writeEnable_o;
  logic [31:0] wb_data_o;
  logic [31:0] HI_o;
  logic [31:0] LO_o;

  int checks   = 0;
  int failures = 0;

  // Expected register-file writes: {addr, data}
  logic [36:0] exp_q[$];

  hilo_pipe dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .writeAddr_i       (writeAddr_i),
    .writeEnable_i     (writeEnable_i),
    .writeHILO_i       (writeHILO_i),
    .HI_data_i         (HI_data_i),
    .LO_data_i         (LO_data_i),
    .mem_writeAddr_o   (mem_writeAddr_o),
    .mem_writeEnable_o (mem_writeEnable_o),
    .mem_data_o        (mem_data_o),
    .wb_writeAddr_o    (wb_writeAddr_o),
    .wb_writeEnable_o  (wb_writeEnable_o),
    .wb_data_o         (wb_data_o),
    .HI_o              (HI_o),
    .LO_o              (LO_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    writeAddr_i   = 5'd0;
    writeEnable_i = 1'b0;
    writeHILO_i   = 2'b00;
    HI_data_i     = 32'd0;
    LO_data_i     = 32'd0;
  endtask

  task automatic ex_drive(input logic [4:0] addr, input logic we,
                          input logic [1:0] hilo, input logic [31:0] hi,
                          input logic [31:0] lo);
    writeAddr_i   = addr;
    writeEnable_i = we;
    writeHILO_i   = hilo;
    HI_data_i     = hi;
    LO_data_i     = lo;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && wb_writeEnable_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got addr=%0d data=0x%08h expected no write",
                 wb_writeAddr_o, wb_data_o);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wb_writeAddr_o, wb_data_o} !== e) begin
          failures++;
          $display("FAIL wb_write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                   wb_writeAddr_o, wb_data_o, e[36:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [4:0]  burst_addr [4];
  logic [31:0] burst_data [4];

  initial begin
    ex_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_HI_o", HI_o, 32'd0);
    chk("rst_LO_o", LO_o, 32'd0);
    chk("rst_mem_we", {31'd0, mem_writeEnable_o}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_writeEnable_o}, 32'd0);

    // Preload HI_r=0x1234, drain, confirm it is architectural
    ex_drive(5'd0, 1'b0, 2'b10, 32'h1234, 32'd0);
    tick();
    ex_idle();
    tick(); tick(); tick();
    chk("preload_HI_r", HI_o, 32'h1234);

    // Pending HI write in MEM, then reset: everything clears, pending discarded
    ex_drive(5'd4, 1'b1, 2'b11, 32'h5678, 32'h9abc);
    tick();
    ex_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_HI_o", HI_o, 32'd0);
    chk("rst2_LO_o", LO_o, 32'd0);
    chk("rst2_mem", {26'd0, mem_writeAddr_o, mem_writeEnable_o} | mem_data_o, 32'd0);
    chk("rst2_wb", {26'd0, wb_writeAddr_o, wb_writeEnable_o} | wb_data_o, 32'd0);
    tick(); tick();
    chk("rst2_HI_r_after", HI_o, 32'd0);

    // GPR pipeline: addr 5, 0xDEADBEEF
    ex_drive(5'd5, 1'b1, 2'b00, 32'd0, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    ex_idle();
    chk("gpr_mem_we", {31'd0, mem_writeEnable_o}, 32'd1);
    chk("gpr_mem_addr", {27'd0, mem_writeAddr_o}, 32'd5);
    chk("gpr_mem_data", mem_data_o, 32'hDEADBEEF);
    chk("gpr_wb_we_c1", {31'd0, wb_writeEnable_o}, 32'd0);
    tick();
    chk("gpr_wb_we_c2", {31'd0, wb_writeEnable_o}, 32'd1);
    tick();
    chk("gpr_wb_bubble", {31'd0, wb_writeEnable_o}, 32'd0);

    // $0 suppression
    ex_drive(5'd0, 1'b1, 2'b00, 32'd0, 32'hFFFFFFFF);
    tick();
    ex_idle();
    chk("zero_mem_we", {31'd0, mem_writeEnable_o}, 32'd0);
    tick();
    chk("zero_wb_we", {31'd0, wb_writeEnable_o}, 32'd0);
    tick();

    // HI/LO forwarding: MULT then HI-only write
    ex_drive(5'd0, 1'b0, 2'b11, 32'h00000001, 32'h80000000);
    tick();
    chk("fwd_c1_HI", HI_o, 32'h00000001);
    chk("fwd_c1_LO", LO_o, 32'h80000000);
    ex_drive(5'd0, 1'b0, 2'b10, 32'h00000022, 32'h00000033);
    tick();
    ex_idle();
    chk("fwd_c2_HI", HI_o, 32'h00000022);
    chk("fwd_c2_LO", LO_o, 32'h80000000);
    tick(); tick(); tick();
    chk("fwd_final_HI_r", HI_o, 32'h00000022);
    chk("fwd_final_LO_r", LO_o, 32'h80000000);

    // Back-to-back GPR writes through the scoreboard
    burst_addr[0] = 5'd1;  burst_data[0] = 32'h11111111;
    burst_addr[1] = 5'd31; burst_data[1] = 32'hA5A5A5A5;
    burst_addr[2] = 5'd16; burst_data[2] = 32'h00000000;
    burst_addr[3] = 5'd2;  burst_data[3] = 32'hFFFF0000;
    for (int i = 0; i < 4; i++) begin
      ex_drive(burst_addr[i], 1'b1, 2'b00, 32'd0, burst_data[i]);
      exp_q.push_back({burst_addr[i], burst_data[i]});
      tick();
    end
    ex_idle();
    tick(); tick(); tick();

    // Stall 3 cycles with HI write 0x55 (plus GPR write) held in MEM
    ex_drive(5'd7, 1'b1, 2'b10, 32'h55, 32'h77);
    exp_q.push_back({5'd7, 32'h77});
    tick();
    ex_idle();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_HI_o", HI_o, 32'h55);
      chk("stall_wb_we", {31'd0, wb_writeEnable_o}, 32'd0);
    end
    stall_i = 1'b0;
    tick();
    chk("release_wb_we", {31'd0, wb_writeEnable_o}, 32'd1);
    chk("release_HI_o", HI_o, 32'h55);
    tick();
    chk("stall_commit_HI_r", HI_o, 32'h55);
    tick();

    // Flush alone kills the EX instruction
    ex_drive(5'd3, 1'b1, 2'b01, 32'd0, 32'h3);
    flush_i = 1'b1;
    tick();
    ex_idle();
    chk("flush_mem_we", {31'd0, mem_writeEnable_o}, 32'd0);
    chk("flush_LO_o", LO_o, 32'h80000000);

    // Flush and stall together with LO write 0x99 in EX
    ex_drive(5'd9, 1'b1, 2'b01, 32'd0, 32'h99);
    flush_i = 1'b1;
    stall_i = 1'b1;
    tick();
    ex_idle();
    chk("fs_mem_we", {31'd0, mem_writeEnable_o}, 32'd0);
    chk("fs_mem_data", mem_data_o, 32'd0);
    chk("fs_wb_we", {31'd0, wb_writeEnable_o}, 32'd0);
    chk("fs_LO_o", LO_o, 32'h80000000);
    tick(); tick(); tick();
    chk("fs_LO_r_final", LO_o, 32'h80000000);

    // Every expected write must have appeared
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
